sys_array_tiled: RTL and testbench

SYS_ARRAY_TILED -- requirements
Module: sys_array_tiled

---
 rtl/sys_array_tiled.sv | 189 ++++++++++++++++++
 tb/tb_sys_array_tiled.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_tiled.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_tiled
// Brief    : Output-stationary systolic array, C = A x B over a ROWS x COLS PE
//            grid with skewed operand feed; SYS_ARRAY_TILED_ACC_EN adds an
//            accumulate input that keeps the previous result on start.
// Revision : 1.0
// ============================================================================
module sys_array_tiled #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int DEPTH_K    = 4,
    localparam int OUT_WIDTH  = 2 * DATA_WIDTH + $clog2(DEPTH_K)
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          load_params,
    input  logic                                          start_comp,
`ifdef SYS_ARRAY_TILED_ACC_EN
    input  logic                                          accumulate,
`endif
    input  logic [0:ROWS-1][0:DEPTH_K-1][DATA_WIDTH-1:0]  input_data_a,
    input  logic [0:DEPTH_K-1][0:COLS-1][DATA_WIDTH-1:0]  input_data_b,
    output logic                                          ready,
    output logic [0:ROWS-1][0:COLS-1][OUT_WIDTH-1:0]      out_data,
    output logic [15:0]                                   cnt
);

    localparam int          T_CYCLES = DEPTH_K + ROWS + COLS - 1;
    localparam logic [15:0] T_LAST   = 16'(T_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                         state_q, state_d;
    logic [15:0]                                    cnt_q, cnt_d;
    logic [0:ROWS-1][0:DEPTH_K-1][DATA_WIDTH-1:0]   a_buf_q, a_buf_d;
    logic [0:DEPTH_K-1][0:COLS-1][DATA_WIDTH-1:0]   b_buf_q, b_buf_d;
    logic [0:ROWS-1][0:COLS-1][OUT_WIDTH-1:0]       out_q, out_d;

    logic [DATA_WIDTH-1:0]   a_fwd_q [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   a_fwd_d [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   b_fwd_q [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   b_fwd_d [ROWS][COLS];
    logic [OUT_WIDTH-1:0]    acc_q   [ROWS][COLS];
    logic [OUT_WIDTH-1:0]    acc_d   [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   a_pe    [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   b_pe    [ROWS][COLS];
    logic [2*DATA_WIDTH-1:0] prod    [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   a_edge  [ROWS];
    logic [DATA_WIDTH-1:0]   b_edge  [COLS];

    logic feeding;
    logic last_cycle;
    logic accept;
    logic clear_acc;

    assign feeding    = (state_q == S_FEED);
    assign last_cycle = feeding && (cnt_q == T_LAST);

`ifdef SYS_ARRAY_TILED_ACC_EN
    assign clear_acc = accept && !accumulate;
`else
    assign clear_acc = accept;
`endif

    // load_params wins over start_comp; both are ignored while feeding
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_params) begin
                    a_buf_d = input_data_a;
                    b_buf_d = input_data_b;
                end else if (start_comp) begin
                    accept  = 1'b1;
                    state_d = S_FEED;
                    cnt_d   = '0;
                end
            end
            S_FEED: begin
                cnt_d = cnt_q + 16'd1;
                if (last_cycle) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Skewed edge feed: row i sees A[i][t-i], column j sees B[t-j][j]
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_edge[i] = '0;
            for (int k = 0; k < DEPTH_K; k++) begin
                if (cnt_q == 16'(i + k)) begin
                    a_edge[i] = a_buf_q[i][k];
                end
            end
        end
        for (int j = 0; j < COLS; j++) begin
            b_edge[j] = '0;
            for (int k = 0; k < DEPTH_K; k++) begin
                if (cnt_q == 16'(j + k)) begin
                    b_edge[j] = b_buf_q[k][j];
                end
            end
        end
    end

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < ROWS; i++) begin
            a_pe[i][0] = a_edge[i];
            for (int j = 1; j < COLS; j++) begin
                a_pe[i][j] = a_fwd_q[i][j-1];
            end
        end
        for (int j = 0; j < COLS; j++) begin
            b_pe[0][j] = b_edge[j];
            for (int i = 1; i < ROWS; i++) begin
                b_pe[i][j] = b_fwd_q[i-1][j];
            end
        end
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                prod[i][j]    = (2*DATA_WIDTH)'(a_pe[i][j]) * (2*DATA_WIDTH)'(b_pe[i][j]);
                a_fwd_d[i][j] = a_fwd_q[i][j];
                b_fwd_d[i][j] = b_fwd_q[i][j];
                acc_d[i][j]   = acc_q[i][j];
                if (accept) begin
                    a_fwd_d[i][j] = '0;
                    b_fwd_d[i][j] = '0;
                    if (clear_acc) begin
                        acc_d[i][j] = '0;
                    end
                end else if (feeding) begin
                    a_fwd_d[i][j] = a_pe[i][j];
                    b_fwd_d[i][j] = b_pe[i][j];
                    acc_d[i][j]   = acc_q[i][j] + OUT_WIDTH'(prod[i][j]);
                end
                // Results become visible only on the FEED->DONE edge
                if (last_cycle) begin
                    out_d[i][j] = acc_d[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_buf_q <= '0;
            b_buf_q <= '0;
            out_q   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_fwd_q[i][j] <= '0;
                    b_fwd_q[i][j] <= '0;
                    acc_q[i][j]   <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
            out_q   <= out_d;
            a_fwd_q <= a_fwd_d;
            b_fwd_q <= b_fwd_d;
            acc_q   <= acc_d;
        end
    end

    assign ready    = (state_q != S_FEED);
    assign out_data = out_q;
    assign cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_array_tiled.sv
`default_nettype none
// tb_sys_array_tiled: vector table plus result scoreboard for sys_array_tiled
// at default parameters (4x4x4, 8-bit elements, 18-bit results).
module tb_sys_array_tiled;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int K  = 4;
    localparam int OW = 18;
    localparam int T  = K + R + C - 1;

    typedef logic [0:R-1][0:K-1][DW-1:0] mat_a_t;
    typedef logic [0:K-1][0:C-1][DW-1:0] mat_b_t;
    typedef logic [0:R-1][0:C-1][OW-1:0] res_t;
    typedef struct {
        string  name;
        mat_a_t a;
        mat_b_t b;
        int     const_val;
    } vec_t;

    logic   clk          = 1'b0;
    logic   reset_n      = 1'b1;
    logic   load_params  = 1'b0;
    logic   start_comp   = 1'b0;
`ifdef SYS_ARRAY_TILED_ACC_EN
    logic   accumulate   = 1'b0;
`endif
    mat_a_t input_data_a = '0;
    mat_b_t input_data_b = '0;
    logic        ready;
    res_t        out_data;
    logic [15:0] cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];

    sys_array_tiled dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_params  (load_params),
        .start_comp   (start_comp),
`ifdef SYS_ARRAY_TILED_ACC_EN
        .accumulate   (accumulate),
`endif
        .input_data_a (input_data_a),
        .input_data_b (input_data_b),
        .ready        (ready),
        .out_data     (out_data),
        .cnt          (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic res_t ref_mul(input mat_a_t a, input mat_b_t b);
        res_t r;
        int   s;
        for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
                s = 0;
                for (int k = 0; k < K; k++) begin
                    s += int'(a[i][k]) * int'(b[k][j]);
                end
                r[i][j] = OW'(s);
            end
        end
        return r;
    endfunction

    function automatic res_t fill_res(input int v);
        res_t r;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                r[i][j] = OW'(v);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic chk_res(input string name, input res_t act, input res_t req);
        int bi;
        int bj;
        bi = -1;
        bj = -1;
        n_checks++;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                if (act[i][j] !== req[i][j] && bi < 0) begin
                    bi = i;
                    bj = j;
                end
        if (bi < 0) n_pass++;
        else $display("FAIL %s: out_data[%0d][%0d] got %0d, required %0d",
                      name, bi, bj, act[bi][bj], req[bi][bj]);
    endtask

    task automatic do_load(input mat_a_t a, input mat_b_t b);
        @(negedge clk);
        input_data_a = a;
        input_data_b = b;
        load_params  = 1'b1;
        @(negedge clk);
        load_params  = 1'b0;
    endtask

    // Returns at the first negedge after the accepting edge
    task automatic do_start(input res_t exp);
        @(negedge clk);
        start_comp = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start_comp = 1'b0;
    endtask

    task automatic wait_done(input string name, input int already);
        int   lat;
        res_t e;
        lat = already;
        while (!ready && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk({name, " latency"}, lat, T);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s scoreboard: got empty queue, required one entry", name);
        end else begin
            e = exp_q.pop_front();
            chk_res({name, " out_data"}, out_data, e);
        end
        chk({name, " cnt"}, cnt, T);
    endtask

    initial begin
        vec_t   vecs[5];
        mat_a_t pat_a;
        mat_a_t ones_a;
        mat_b_t ones_b;
        mat_b_t ident_b;
        mat_b_t at_b;
        res_t   e;
        res_t   prev;
        res_t   pat_as_res;
        int     lat;
        int     gap;

        for (int i = 0; i < R; i++)
            for (int k = 0; k < K; k++)
                pat_a[i][k] = 8'(i * 4 + k + 1);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < C; j++) begin
                ident_b[k][j] = (k == j) ? 8'd1 : 8'd0;
                at_b[k][j]    = 8'(j * 4 + k + 1);
            end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                pat_as_res[i][j] = OW'(pat_a[i][j]);
        ones_a = {R*K{8'd1}};
        ones_b = {K*C{8'd1}};

        vecs[0].name = "ones";    vecs[0].a = ones_a; vecs[0].b = ones_b;  vecs[0].const_val = 4;
        vecs[1].name = "ident";   vecs[1].a = pat_a;  vecs[1].b = ident_b; vecs[1].const_val = -1;
        vecs[2].name = "a_x_at";  vecs[2].a = pat_a;  vecs[2].b = at_b;    vecs[2].const_val = -1;
        vecs[3].name = "all_255"; vecs[3].a = {R*K{8'hFF}}; vecs[3].b = {K*C{8'hFF}}; vecs[3].const_val = 260100;
        vecs[4].name = "random";  vecs[4].const_val = -1;
        for (int i = 0; i < R; i++)
            for (int k = 0; k < K; k++)
                vecs[4].a[i][k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < K; k++)
            for (int j = 0; j < C; j++)
                vecs[4].b[k][j] = 8'($urandom_range(0, 255));

        #1 reset_n = 1'b0;
        #1;
        chk("reset ready", ready, 1);
        chk_res("reset out_data", out_data, '0);
        chk("reset cnt", cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].const_val >= 0) e = fill_res(vecs[v].const_val);
            else if (v == 1)            e = pat_as_res;
            else                        e = ref_mul(vecs[v].a, vecs[v].b);
            do_load(vecs[v].a, vecs[v].b);
            do_start(e);
            wait_done(vecs[v].name, 0);
            prev = e;
        end

        // Load and start during FEED must not disturb the running computation
        do_load(ones_a, ones_b);
        do_start(fill_res(4));
        chk_res("hold during feed", out_data, prev);
        @(negedge clk);
        @(negedge clk);
        input_data_a = {R*K{8'hFF}};
        input_data_b = {K*C{8'hFF}};
        load_params  = 1'b1;
        start_comp   = 1'b1;
        @(negedge clk);
        load_params  = 1'b0;
        start_comp   = 1'b0;
        wait_done("feed interference", 3);
        do_start(fill_res(4));
        wait_done("rerun unchanged buffers", 0);

        // load_params and start_comp together: load only
        @(negedge clk);
        input_data_a = pat_a;
        input_data_b = ident_b;
        load_params  = 1'b1;
        start_comp   = 1'b1;
        @(negedge clk);
        load_params  = 1'b0;
        start_comp   = 1'b0;
        chk("load+start ready", ready, 1);
        chk("load+start cnt", cnt, T);
        @(negedge clk);
        chk("load+start ready later", ready, 1);
        chk_res("load+start out_data", out_data, fill_res(4));
        do_start(pat_as_res);
        wait_done("after load+start", 0);

        // start_comp held high: back-to-back runs with one DONE cycle
        @(negedge clk);
        start_comp = 1'b1;
        exp_q.push_back(pat_as_res);
        @(negedge clk);
        lat = 0;
        while (!ready && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("b2b first latency", lat, T);
        e = exp_q.pop_front();
        chk_res("b2b first out_data", out_data, e);
        gap = 0;
        while (ready && gap < 200) begin
            gap++;
            @(negedge clk);
        end
        start_comp = 1'b0;
        chk("b2b done gap", gap, 1);
        exp_q.push_back(pat_as_res);
        wait_done("b2b second", 0);

        // Reset in the middle of FEED aborts the run
        do_load(ones_a, ones_b);
        @(negedge clk);
        start_comp = 1'b1;
        @(negedge clk);
        start_comp = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset ready", ready, 1);
        chk_res("midreset out_data", out_data, '0);
        chk("midreset cnt", cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (T + 2) @(negedge clk);
        chk_res("after reset out_data", out_data, '0);
        chk("after reset ready", ready, 1);
        do_start('0);
        wait_done("zero run after reset", 0);
        do_load(ones_a, ones_b);
        do_start(fill_res(4));
        wait_done("run after reset", 0);

`ifdef SYS_ARRAY_TILED_ACC_EN
        accumulate = 1'b1;
        do_start(fill_res(8));
        wait_done("accumulate on", 0);
        accumulate = 1'b0;
        do_start(fill_res(4));
        wait_done("accumulate off", 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
